// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions for the reader and the display writer.
// Patterns are active-low, ordered bit6..bit0 = g..a.
// Also holds the index constants for the letters and the pairing FSM state type.
package seven_seg_pkg;

    // Digits 0..8
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;

    // Letters A..H (indices 9..16)
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_G = 7'b1000010;
    localparam logic [6:0] SEG_H = 7'b0001001;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [4:0] IDX_A = 5'd9;
    localparam logic [4:0] IDX_H = 5'd16;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_HAVE_COL = 1'b1
    } pair_state_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   pattern  in  7  active-low segment pattern (g..a)
//   is_valid out 1  pattern is one of the 17 known symbols
//   is_blank out 1  pattern is all segments off
//   index    out 5  0..8 digits, 9..16 letters A..H (0 when not valid)
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       is_valid,
    output logic       is_blank,
    output logic [4:0] index
);

    always_comb begin
        is_valid = 1'b1;
        is_blank = 1'b0;
        index    = 5'd0;
        case (pattern)
            SEG_0:     index = 5'd0;
            SEG_1:     index = 5'd1;
            SEG_2:     index = 5'd2;
            SEG_3:     index = 5'd3;
            SEG_4:     index = 5'd4;
            SEG_5:     index = 5'd5;
            SEG_6:     index = 5'd6;
            SEG_7:     index = 5'd7;
            SEG_8:     index = 5'd8;
            SEG_A:     index = 5'd9;
            SEG_B:     index = 5'd10;
            SEG_C:     index = 5'd11;
            SEG_D:     index = 5'd12;
            SEG_E:     index = 5'd13;
            SEG_F:     index = 5'd14;
            SEG_G:     index = 5'd15;
            SEG_H:     index = 5'd16;
            SEG_BLANK: begin
                is_valid = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Seven-segment stream reader: debounces the incoming pattern, emits each
// accepted symbol once on a valid/ready port and pairs a column letter with a
// row digit into a board square.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   seg_in      in  7       raw active-low pattern, sampled every cycle
//   dig_valid   out 1       dig_index holds an accepted symbol
//   dig_ready   in  1       consumer takes dig_index
//   dig_index   out 5       0..8 digits, 9..16 letters A..H
//   sq_valid    out 1       one-cycle pulse: square completed
//   sq_col      out 3       column 0=A..7=H
//   sq_row      out 3       row 0="1"..7="8"
//   err_invalid out 1       one-cycle pulse: unknown non-blank pattern accepted
//   overrun     out 1       sticky: an accepted symbol was dropped
//
// Handshake: a transfer happens on a rising edge where dig_valid && dig_ready.
// While dig_valid is high, dig_index is held stable until that transfer.
// dig_valid never depends combinationally on dig_ready.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] seg_in,
    output logic       dig_valid,
    input  logic       dig_ready,
    output logic [4:0] dig_index,
    output logic       sq_valid,
    output logic [2:0] sq_col,
    output logic [2:0] sq_row,
    output logic       err_invalid,
    output logic       overrun
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES - 1);

    logic [6:0]  s_q;
    logic [3:0]  run_cnt;
    logic        accepted;
    logic        same;
    logic        accept;

    logic        dec_valid;
    logic        dec_blank;
    logic [4:0]  dec_index;

    logic        accept_valid;
    logic        accept_invalid;
    logic        is_letter;

    pair_state_t state, state_d;
    logic [2:0]  col_q, col_d;
    logic        sq_valid_d;
    logic [2:0]  sq_row_d;
    logic        err_d;

    assign same   = (seg_in == s_q);
    // The run counter saturates, so the "accepted" flag is what keeps a long
    // hold from being emitted more than once.
    assign accept = (run_cnt == RUN_MAX) && !accepted;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_q      <= SEG_BLANK;
            run_cnt  <= 4'd0;
            accepted <= 1'b1;
        end else begin
            s_q <= seg_in;
            if (same) begin
                if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + 4'd1;
                end
                if (accept) begin
                    accepted <= 1'b1;
                end
            end else begin
                run_cnt  <= 4'd0;
                accepted <= 1'b0;
            end
        end
    end

    seg_decoder u_dec (
        .pattern  (s_q),
        .is_valid (dec_valid),
        .is_blank (dec_blank),
        .index    (dec_index)
    );

    assign accept_valid   = accept && dec_valid;
    assign accept_invalid = accept && !dec_valid && !dec_blank;
    assign is_letter      = (dec_index >= IDX_A);

    // Single-entry output register; a full, undrained register drops the new symbol.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dig_valid <= 1'b0;
            dig_index <= 5'd0;
            overrun   <= 1'b0;
        end else if (accept_valid) begin
            if (!dig_valid || dig_ready) begin
                dig_valid <= 1'b1;
                dig_index <= dec_index;
            end else begin
                overrun <= 1'b1;
            end
        end else if (dig_valid && dig_ready) begin
            dig_valid <= 1'b0;
        end
    end

    // Pairing FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            col_q       <= 3'd0;
            sq_valid    <= 1'b0;
            sq_col      <= 3'd0;
            sq_row      <= 3'd0;
            err_invalid <= 1'b0;
        end else begin
            state       <= state_d;
            col_q       <= col_d;
            sq_valid    <= sq_valid_d;
            sq_row      <= sq_row_d;
            err_invalid <= err_d;
            if (sq_valid_d) begin
                sq_col <= col_q;
            end
        end
    end

    // Pairing FSM: next state and pulse outputs
    always_comb begin
        state_d    = state;
        col_d      = col_q;
        sq_valid_d = 1'b0;
        sq_row_d   = sq_row;
        err_d      = 1'b0;
        if (accept_invalid) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else if (accept_valid) begin
            if (is_letter) begin
                col_d   = 3'(dec_index - IDX_A);
                state_d = ST_HAVE_COL;
            end else if (state == ST_HAVE_COL) begin
                // Digit 0 is not a legal row; it abandons the pending column.
                state_d = ST_IDLE;
                if (dec_index != 5'd0) begin
                    sq_valid_d = 1'b1;
                    sq_row_d   = 3'(dec_index - 5'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Testbench for seven_seg_reader: directed scenarios plus randomized symbol
// streams, checked each cycle against a sample-history reference model.
module tb_seven_seg_reader;

    localparam int         STABLE = 4;
    localparam logic [6:0] BLANK  = 7'b1111111;
    localparam logic [6:0] BAD    = 7'b0101010;

    logic       clock;
    logic       reset_n;
    logic [6:0] seg_in;
    logic       dig_valid;
    logic       dig_ready;
    logic [4:0] dig_index;
    logic       sq_valid;
    logic [2:0] sq_col;
    logic [2:0] sq_row;
    logic       err_invalid;
    logic       overrun;

    seven_seg_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .dig_valid   (dig_valid),
        .dig_ready   (dig_ready),
        .dig_index   (dig_index),
        .sq_valid    (sq_valid),
        .sq_col      (sq_col),
        .sq_row      (sq_row),
        .err_invalid (err_invalid),
        .overrun     (overrun)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [6:0] pat_tbl [17];

    // reference model state
    logic [6:0] m_last;
    int         m_len;
    bit         m_done;
    bit         m_full;
    bit         m_over;
    int         m_idx;
    int         m_col;
    int         e_sq, e_sqc, e_sqr, e_err;
    logic [4:0] exp_q [$];

    // scenario observations
    int got_q [$];
    int sq_cnt, err_cnt, last_sqc, last_sqr, step_no, first_valid;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -1 = blank, -2 = unrecognised, else symbol index
    function automatic int ref_index(input logic [6:0] p);
        if (p == BLANK) return -1;
        for (int i = 0; i < 17; i++) begin
            if (pat_tbl[i] == p) return i;
        end
        return -2;
    endfunction

    task automatic model_reset();
        m_last = BLANK;
        m_len  = 1;
        m_done = 1'b1;
        m_full = 1'b0;
        m_over = 1'b0;
        m_idx  = 0;
        m_col  = -1;
        e_sq   = 0;
        e_err  = 0;
        exp_q.delete();
    endtask

    // One rising edge of the reference: a symbol is taken once after it has
    // been seen on STABLE consecutive samples.
    task automatic model_edge();
        bit accept;
        bit hs;
        bit loaded;
        int code;
        accept = (m_len >= STABLE) && !m_done;
        hs     = m_full && (dig_ready == 1'b1);
        loaded = 1'b0;
        e_sq   = 0;
        e_err  = 0;
        if (accept) begin
            code = ref_index(m_last);
            if (code == -2) begin
                e_err = 1;
                m_col = -1;
            end else if (code >= 0) begin
                if (!m_full || dig_ready) begin
                    m_full = 1'b1;
                    m_idx  = code;
                    loaded = 1'b1;
                    exp_q.push_back(5'(code));
                end else begin
                    m_over = 1'b1;
                end
                if (code >= 9) begin
                    m_col = code - 9;
                end else if (m_col >= 0 && code >= 1) begin
                    e_sq  = 1;
                    e_sqc = m_col;
                    e_sqr = code - 1;
                    m_col = -1;
                end else begin
                    m_col = -1;
                end
            end
        end
        if (!loaded && hs) m_full = 1'b0;
        if (seg_in == m_last) begin
            if (m_len < 1000) m_len++;
            if (accept) m_done = 1'b1;
        end else begin
            m_last = seg_in;
            m_len  = 1;
            m_done = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("dig_valid", int'(dig_valid), int'(m_full));
        if (m_full) check_eq("dig_index", int'(dig_index), m_idx);
        check_eq("overrun", int'(overrun), int'(m_over));
        check_eq("sq_valid", int'(sq_valid), e_sq);
        if (e_sq != 0) begin
            check_eq("sq_col", int'(sq_col), e_sqc);
            check_eq("sq_row", int'(sq_row), e_sqr);
        end
        check_eq("err_invalid", int'(err_invalid), e_err);
        if (sq_valid) begin
            sq_cnt++;
            last_sqc = int'(sq_col);
            last_sqr = int'(sq_row);
        end
        if (err_invalid) err_cnt++;
    endtask

    // Called at posedge+1 with inputs already applied for the coming edge.
    task automatic step();
        if (dig_valid && dig_ready) begin
            got_q.push_back(int'(dig_index));
            if (exp_q.size() == 0) check_eq("sb_unexpected", int'(dig_index), -1);
            else check_eq("sb_dig", int'(dig_index), int'(exp_q.pop_front()));
        end
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
        if (dig_valid && first_valid < 0) first_valid = step_no;
        step_no++;
    endtask

    task automatic hold(input logic [6:0] p, input int n, input bit rdy);
        seg_in    = p;
        dig_ready = rdy;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic begin_scn();
        got_q.delete();
        sq_cnt      = 0;
        err_cnt     = 0;
        step_no     = 0;
        first_valid = -1;
    endtask

    // Asserts reset mid-cycle and checks the outputs clear without a clock edge.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("rst_dig_valid", int'(dig_valid), 0);
        check_eq("rst_dig_index", int'(dig_index), 0);
        check_eq("rst_sq_valid", int'(sq_valid), 0);
        check_eq("rst_sq_col", int'(sq_col), 0);
        check_eq("rst_sq_row", int'(sq_row), 0);
        check_eq("rst_err", int'(err_invalid), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        pat_tbl[0]  = 7'b1000000;  pat_tbl[1]  = 7'b1111001;
        pat_tbl[2]  = 7'b0100100;  pat_tbl[3]  = 7'b0110000;
        pat_tbl[4]  = 7'b0011001;  pat_tbl[5]  = 7'b0010010;
        pat_tbl[6]  = 7'b0000010;  pat_tbl[7]  = 7'b1111000;
        pat_tbl[8]  = 7'b0000000;  pat_tbl[9]  = 7'b0001000;
        pat_tbl[10] = 7'b0000011;  pat_tbl[11] = 7'b1000110;
        pat_tbl[12] = 7'b0100001;  pat_tbl[13] = 7'b0000110;
        pat_tbl[14] = 7'b0001110;  pat_tbl[15] = 7'b1000010;
        pat_tbl[16] = 7'b0001001;

        reset_n   = 1'b1;
        seg_in    = BLANK;
        dig_ready = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // Single digit: one emission of 2, valid first after edge 4
        begin_scn();
        hold(pat_tbl[2], 10, 1'b1);
        check_eq("single_first_edge", first_valid, 4);
        hold(BLANK, 6, 1'b1);
        check_eq("single_count", got_q.size(), 1);
        if (got_q.size() >= 1) check_eq("single_val", got_q[0], 2);

        // Glitch rejection: 3 held for 3 samples is ignored
        begin_scn();
        hold(pat_tbl[3], 3, 1'b1);
        hold(pat_tbl[7], 8, 1'b1);
        hold(BLANK, 6, 1'b1);
        check_eq("glitch_count", got_q.size(), 1);
        if (got_q.size() >= 1) check_eq("glitch_val", got_q[0], 7);

        // Square entry C then 5 -> column 2, row 4
        begin_scn();
        hold(pat_tbl[11], 6, 1'b1);
        hold(BLANK, 6, 1'b1);
        hold(pat_tbl[5], 6, 1'b1);
        hold(BLANK, 6, 1'b1);
        check_eq("sq_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check_eq("sq_dig0", got_q[0], 11);
            check_eq("sq_dig1", got_q[1], 5);
        end
        check_eq("sq_pulses", sq_cnt, 1);
        check_eq("sq_last_col", last_sqc, 2);
        check_eq("sq_last_row", last_sqr, 4);

        // Long hold: saturating run counter, exactly one emission
        begin_scn();
        hold(pat_tbl[8], 40, 1'b1);
        hold(BLANK, 6, 1'b1);
        check_eq("long_count", got_q.size(), 1);

        // Backpressure: 1 held, 4 dropped, overrun set
        begin_scn();
        hold(pat_tbl[1], 6, 1'b0);
        hold(BLANK, 6, 1'b0);
        hold(pat_tbl[4], 6, 1'b0);
        hold(BLANK, 2, 1'b0);
        check_eq("bp_valid", int'(dig_valid), 1);
        check_eq("bp_index", int'(dig_index), 1);
        check_eq("bp_overrun", int'(overrun), 1);
        hold(BLANK, 1, 1'b1);
        check_eq("bp_drained", int'(dig_valid), 0);
        hold(BLANK, 3, 1'b1);
        check_eq("bp_count", got_q.size(), 1);

        // Invalid pattern between A and 3
        begin_scn();
        hold(pat_tbl[9], 6, 1'b1);
        hold(BLANK, 6, 1'b1);
        hold(BAD, 6, 1'b1);
        hold(BLANK, 6, 1'b1);
        hold(pat_tbl[3], 6, 1'b1);
        hold(BLANK, 6, 1'b1);
        check_eq("inv_err_pulses", err_cnt, 1);
        check_eq("inv_sq_pulses", sq_cnt, 0);
        check_eq("inv_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check_eq("inv_dig0", got_q[0], 9);
            check_eq("inv_dig1", got_q[1], 3);
        end

        // Reset mid-run, then E held
        begin_scn();
        hold(pat_tbl[13], 2, 1'b1);
        do_reset();
        hold(pat_tbl[13], 6, 1'b1);
        hold(BLANK, 6, 1'b1);
        check_eq("rst_count", got_q.size(), 1);
        if (got_q.size() >= 1) check_eq("rst_val", got_q[0], 13);

        // Randomized symbol stream with random back-pressure
        for (int n = 0; n < 300; n++) begin
            int         kind;
            int         len;
            logic [6:0] p;
            kind = $urandom_range(0, 9);
            if (kind <= 1)      p = BLANK;
            else if (kind == 2) p = 7'($urandom_range(0, 127));
            else                p = pat_tbl[$urandom_range(0, 16)];
            len = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 7);
            seg_in = p;
            for (int i = 0; i < len; i++) begin
                dig_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        hold(BLANK, 8, 1'b1);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Decodes a seven-segment pattern stream back into digit indices, the inverse of the display digit writer. Each pattern must be stable for a set number of cycles before it is accepted. Accepted indices are emitted once on a valid/ready output. A small FSM pairs a column letter (A–H) followed by a row number (1–8) into a checkers board square for the move-entry path of the FPGA processor.

## Interface

- STABLE_CYCLES, 4: consecutive identical samples required before acceptance (legal range 2–15).
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  raw segment pattern, active-low, bit6..bit0 = g..a; sampled every cycle.
- dig_valid  out  1  dig_index holds an accepted digit.
- dig_ready  in  1  consumer accepts dig_index when dig_valid && dig_ready.
- dig_index  out  5  decoded index: 0–8 are digits, 9–16 are A–H.
- sq_valid  out  1  one-cycle pulse when a square is completed.
- sq_col  out  3  column, 0 = A … 7 = H.
- sq_row  out  3  row, 0 = "1" … 7 = "8".
- err_invalid  out  1  one-cycle pulse when an unrecognised, non-blank pattern is accepted.
- overrun  out  1  sticky; set when an accepted digit is dropped; cleared only by reset.

## Operation

- **Encoding (g..a, active-low):**
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000.
  - Letters: A(9)=0001000, B(10)=0000011, C(11)=1000110, D(12)=0100001, E(13)=0000110, F(14)=0001110, G(15)=1000010, H(16)=0001001.
  - Blank is 1111111. Every other pattern is invalid.
- **Stability and acceptance:**
  - seg_in is registered into s_q.
  - Run counter run_cnt increments, saturating, while seg_in == s_q; it clears to 0 when they differ.
  - A pattern is accepted once per stable run, when run_cnt reaches STABLE_CYCLES-1.
  - An "accepted" flag blocks re-acceptance until seg_in changes. Repeating a symbol requires a different pattern (normally blank) in between.
- **Accepted pattern handling:**
  - Blank: produces no output and leaves the FSM unchanged.
  - Invalid: pulses err_invalid and sends the FSM to IDLE; no dig output.
  - Valid: loaded into the dig output register and presented to the FSM.
- **Output register (single entry):**
  - Loads when empty, or when full and being drained in the same cycle (dig_valid && dig_ready).
  - If full and not draining, the new digit is dropped and overrun is set. The held value is unchanged.
- **Pairing FSM, states IDLE and HAVE_COL:**
  - IDLE + letter: latch col = index-9, go to HAVE_COL.
  - IDLE + digit: stay in IDLE.
  - HAVE_COL + digit 1–8: pulse sq_valid with the latched col and row = index-1, go to IDLE.
  - HAVE_COL + letter: replace col, stay in HAVE_COL.
  - HAVE_COL + digit 0 or invalid pattern: go to IDLE.
- The square path ignores dig_ready; it is never back-pressured.

## Timing

- **Reset values:**
  - All outputs are 0.
  - s_q = 1111111, run_cnt = 0, accepted flag set, FSM = IDLE, col = 0.
  - Reset takes effect asynchronously mid-operation and discards any partial run or pending column.
- **Latency:** a new value applied at seg_in before edge 0 and held constant gives dig_valid high after edge STABLE_CYCLES (edge 4 by default). sq_valid and err_invalid pulse on the same edge as the corresponding acceptance.
- A held pattern shorter than STABLE_CYCLES samples produces nothing.
- dig_valid stays high and dig_index stays stable until the handshake completes. dig_valid drops on the edge after the handshake unless a new digit loads on that same edge.
- Accept while full with dig_ready=1 in the same cycle: no drop; the new value appears on the next edge.
- run_cnt saturates at STABLE_CYCLES-1; long holds do not wrap.

## Structure

- **Package seven_seg_pkg:**
  - The 17 pattern constants and BLANK.
  - Index constants IDX_A = 9 and IDX_H = 16.
  - FSM state typedef.
  - The same constants are to be shared with the display writer.
- **Sub-module seg_decoder (combinational):** maps a 7-bit pattern to {is_valid, is_blank, index[4:0]}.
- **Top level:** the sampler/stability counter, output register and pairing FSM.

## Test plan

- **Single digit:** hold 0100100 for 10 cycles with dig_ready=1 -> dig_valid for exactly one cycle, dig_index=2, starting at edge 4; no further emission.
- **Glitch rejection:** 0110000 for 3 cycles, then 1111000 held -> only dig_index=7 is emitted.
- **Square entry:** C held 6 cycles, blank held 6 cycles, 5 held 6 cycles -> dig stream 11 then 5; sq_valid pulse with sq_col=2, sq_row=4.
- **Backpressure:** dig_ready=0; enter 1, blank, 4 -> dig_index stays 1 and overrun=1. Raise dig_ready -> dig_valid drops after one handshake.
- **Invalid pattern:** enter A, then 0101010 held, then 3 -> err_invalid pulses once; no sq_valid; dig stream is 9 then 3.
- **Reset mid-run:** assert reset_n=0 after 2 cycles of E -> all outputs 0 immediately. Release and hold E for 6 cycles -> one dig_index=13.
